// File: rtl/disp_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver:
// blank pattern, active-low hex decode table and a ceiling-log2 for widths.
package disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment pattern, bit order g..a
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++)
      if ((64'd1 << i) < 64'(v)) r = int'(i) + 1;
    return r;
  endfunction

endpackage

// File: rtl/disp_seg_dec.sv
// Registered hex -> 7-segment decoder (active-low, g..a) with a blank override.
module disp_seg_dec
  import disp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex,
  input  logic       blank,
  output logic [6:0] seg7
);

  always_ff @(posedge clk) begin
    if (rst)        seg7 <= SEG_BLANK[6:0];
    else if (blank) seg7 <= SEG_BLANK[6:0];
    else            seg7 <= hex7(hex);
  end

endmodule

// File: rtl/disp_scan_n.sv
// NDIG-digit multiplexed 7-segment scan driver with frame-synchronous latch,
// decimal point, per-digit blink and PWM brightness. Optional macro: DISP_LZB_EN.
module disp_scan_n
  import disp_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DIM_W   = 3,
  parameter int BLINK_T = 250,
  localparam int PW     = log2c(NDIG)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] dat,
  input  logic              dp_en,
  input  logic [PW-1:0]     dp_ptr,
  input  logic [NDIG-1:0]   blink_mask,
  input  logic [DIM_W-1:0]  bright,
  output logic [NDIG-1:0]   an,
  output logic [7:0]        seg,
  output logic              ce_tick,
  output logic              frame
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PRW = log2c(DIV);
  localparam int BW  = (BLINK_T > 1) ? log2c(BLINK_T) : 1;

  logic [PRW-1:0]    presc;
  logic [PW-1:0]     ptr;
  logic [BW-1:0]     bcnt;
  logic              phase;
  logic [4*NDIG-1:0] sh_dat;
  logic              sh_dp_en;
  logic [PW-1:0]     sh_dp_ptr;
  logic [NDIG-1:0]   sh_mask;
  logic [DIM_W-1:0]  sh_bright;

  logic              dp_n;
  logic [6:0]        seg7;
  logic [31:0]       thr;
  logic              lit;
  logic              blink_blank;
  logic              digit_lzb;
  logic              pre_last;
  logic              pre_next_last;

  assign pre_last      = (presc == PRW'(DIV - 1));
  assign pre_next_last = (presc == PRW'(DIV - 2));
  assign thr           = ((32'(sh_bright) + 32'd1) * 32'(DIV)) >> DIM_W;
  assign lit           = 32'(presc) < thr;
  assign blink_blank   = phase && sh_mask[ptr];

`ifdef DISP_LZB_EN
  logic [NDIG-1:0] lzb_mask;

  // A digit is blanked when it and every digit above it are zero
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lzb_mask   = '0;
    for (int unsigned i = NDIG - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (sh_dat[4*i +: 4] == 4'h0);
      lzb_mask[i] = upper_zero;
    end
  end

  assign digit_lzb = lzb_mask[ptr];
`else
  assign digit_lzb = 1'b0;
`endif

  // ce_tick/frame are registered one count early so they line up with presc==DIV-1
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      ptr       <= '0;
      bcnt      <= '0;
      phase     <= 1'b0;
      sh_dat    <= '0;
      sh_dp_en  <= 1'b0;
      sh_dp_ptr <= '0;
      sh_mask   <= '0;
      sh_bright <= '0;
      ce_tick   <= 1'b0;
      frame     <= 1'b0;
      an        <= '1;
      dp_n      <= 1'b1;
    end else begin
      presc   <= pre_last ? '0 : presc + 1'b1;
      ce_tick <= pre_next_last;
      frame   <= pre_next_last && (ptr == PW'(NDIG - 1));

      if (ce_tick) begin
        ptr <= (ptr == PW'(NDIG - 1)) ? '0 : ptr + 1'b1;
        if (bcnt == BW'(BLINK_T - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end

      if (frame) begin
        sh_dat    <= dat;
        sh_dp_en  <= dp_en;
        sh_dp_ptr <= dp_ptr;
        sh_mask   <= blink_mask;
        sh_bright <= bright;
      end

      an   <= lit ? ~(NDIG'(1) << ptr) : '1;
      dp_n <= !(lit && sh_dp_en && (sh_dp_ptr == ptr) && !blink_blank);
    end
  end

  disp_seg_dec u_dec (
    .clk   (clk),
    .rst   (rst),
    .hex   (sh_dat[{ptr, 2'b00} +: 4]),
    .blank (!lit || blink_blank || digit_lzb),
    .seg7  (seg7)
  );

  assign seg = {dp_n, seg7};

endmodule

// File: tb/tb_disp_scan_n.sv
// Self-checking bench for disp_scan_n (NDIG=4, DIV=10, BLINK_T=4) against a
// time-indexed reference model: slot, digit, PWM and blink phase from cycle count.
module tb_disp_scan_n;

  localparam int NDIG = 4;
  localparam int DIV  = 10;
  localparam int BT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] dat;
  logic        dp_en;
  logic [1:0]  dp_ptr;
  logic [3:0]  blink_mask;
  logic [2:0]  bright;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        ce_tick;
  logic        frame;

  always #5 clk = ~clk;

  disp_scan_n #(
    .NDIG    (4),
    .CLK_HZ  (1000),
    .SCAN_HZ (100),
    .DIM_W   (3),
    .BLINK_T (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dat        (dat),
    .dp_en      (dp_en),
    .dp_ptr     (dp_ptr),
    .blink_mask (blink_mask),
    .bright     (bright),
    .an         (an),
    .seg        (seg),
    .ce_tick    (ce_tick),
    .frame      (frame)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: k = clock cycles since reset release, plus the latched frame inputs
  int          k;
  logic [15:0] m_dat;
  logic        m_dp_en;
  logic [1:0]  m_dp_ptr;
  logic [3:0]  m_mask;
  logic [2:0]  m_bright;
  logic [3:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_ce;
  logic        e_fr;

  task automatic model_out(input int st, output logic [3:0] a, output logic [7:0] s);
    int   p, sl, d, thr;
    bit   blk, lz;
    logic [15:0] tmp;
    p   = st % DIV;
    sl  = st / DIV;
    d   = sl % NDIG;
    thr = ((int'(m_bright) + 1) * DIV) / 8;
    blk = m_mask[d] && ((sl / BT) % 2 == 1);
    lz  = 1'b0;
`ifdef DISP_LZB_EN
    lz = (d > 0) && ((m_dat >> (4 * d)) == 16'h0);
`endif
    if (p >= thr) begin
      a = 4'hF;
      s = 8'hFF;
    end else begin
      a    = ~(4'b0001 << d);
      tmp  = m_dat >> (4 * d);
      s[6:0] = (blk || lz) ? 7'h7F : hex_tbl[tmp[3:0]];
      s[7]   = !(m_dp_en && (int'(m_dp_ptr) == d) && !blk);
    end
  endtask

  task automatic tick();
    if (rst) begin
      @(posedge clk); #1;
      k = 0;
      m_dat = '0; m_dp_en = 1'b0; m_dp_ptr = '0; m_mask = '0; m_bright = '0;
      e_an = 4'hF; e_seg = 8'hFF; e_ce = 1'b0; e_fr = 1'b0;
    end else begin
      model_out(k, e_an, e_seg);
      if ((k % DIV) == DIV - 1 && ((k / DIV) % NDIG) == NDIG - 1) begin
        m_dat = dat; m_dp_en = dp_en; m_dp_ptr = dp_ptr; m_mask = blink_mask; m_bright = bright;
      end
      @(posedge clk); #1;
      k++;
      e_ce = (k % DIV) == DIV - 1;
      e_fr = e_ce && ((k / DIV) % NDIG) == NDIG - 1;
    end
  endtask

  // Advance until frame is seen (bounded); ok=0 on timeout
  task automatic run_to_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (frame === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int first_ce, gap;
    rst = 1'b1;
    dat = '0; dp_en = 0; dp_ptr = '0; blink_mask = '0; bright = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total += 4;
      if (an !== 4'hF) $display("FAIL reset_an: got %h expected f", an); else n_pass++;
      if (seg !== 8'hFF) $display("FAIL reset_seg: got %h expected ff", seg); else n_pass++;
      if (ce_tick !== 1'b0) $display("FAIL reset_ce: got %b expected 0", ce_tick); else n_pass++;
      if (frame !== 1'b0) $display("FAIL reset_frame: got %b expected 0", frame); else n_pass++;
    end
    rst = 1'b0;
    // ce_tick is high during the 10th cycle after release, i.e. after 9 edges
    first_ce = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ce_tick === 1'b1) begin first_ce = i; break; end
    end
    n_total++;
    if (first_ce != DIV - 1) $display("FAIL first_ce: got %0d expected %0d", first_ce, DIV - 1);
    else n_pass++;
    gap = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (frame === 1'b1) begin gap = i; break; end
    end
    n_total++;
    if (gap != 30) $display("FAIL first_frame_gap: got %0d expected 30", gap); else n_pass++;
    gap = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (frame === 1'b1) begin gap = i; break; end
    end
    n_total++;
    if (gap != 40) $display("FAIL frame_period: got %0d expected 40", gap); else n_pass++;
  endtask

  task automatic test_scan();
    bit ok;
    dat = 16'h1234; bright = 3'd7; dp_en = 0; blink_mask = '0;
    run_to_frame(ok);
    n_total++;
    if (!ok) $display("FAIL scan_frame_timeout: got 0 expected 1"); else n_pass++;
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        n_total++;
        if (an !== 4'hE || seg !== 8'h99)
          $display("FAIL scan_digit0: got an=%h seg=%h expected an=e seg=99", an, seg);
        else n_pass++;
      end
      if (i == 10) begin
        n_total++;
        if (an !== 4'hD || seg !== 8'hB0)
          $display("FAIL scan_digit1: got an=%h seg=%h expected an=d seg=b0", an, seg);
        else n_pass++;
      end
      n_total++;
      if (an !== e_an || seg !== e_seg)
        $display("FAIL scan_model: got an=%h seg=%h expected an=%h seg=%h", an, seg, e_an, e_seg);
      else n_pass++;
    end
  endtask

  task automatic test_bright();
    bit ok;
    int cnt [4];
    int bv [2] = '{0, 3};
    int want;
    for (int b = 0; b < 2; b++) begin
      bright = 3'(bv[b]);
      run_to_frame(ok);
      n_total++;
      if (!ok) $display("FAIL bright_frame_timeout: got 0 expected 1"); else n_pass++;
      tick();
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      for (int i = 0; i < 40; i++) begin
        tick();
        for (int d = 0; d < 4; d++) if (an === ~(4'b0001 << d)) cnt[d]++;
      end
      want = ((bv[b] + 1) * DIV) / 8;
      for (int d = 0; d < 4; d++) begin
        n_total++;
        if (cnt[d] != want) $display("FAIL bright%0d_digit%0d: got %0d expected %0d", bv[b], d, cnt[d], want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_tearing();
    bit ok;
    logic [15:0] old_v;
    logic [15:0] tmp;
    int d;
    dat = 16'h1234; bright = 3'd7;
    old_v = 16'h1234;
    run_to_frame(ok);
    tick();
    for (int i = 0; i < 15; i++) tick();
    dat = 16'hABCD;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (an !== 4'hF) begin
        d = (an === 4'hE) ? 0 : (an === 4'hD) ? 1 : (an === 4'hB) ? 2 : 3;
        tmp = old_v >> (4 * d);
        n_total++;
        if (seg[6:0] !== hex_tbl[tmp[3:0]])
          $display("FAIL tear_old_digit%0d: got %h expected %h", d, seg[6:0], hex_tbl[tmp[3:0]]);
        else n_pass++;
      end
      if (frame === 1'b1) break;
    end
    tick();
    tick();
    n_total++;
    if (an !== 4'hE || seg[6:0] !== 7'h21)
      $display("FAIL tear_new_digit0: got an=%h seg=%h expected an=e seg=21", an, seg[6:0]);
    else n_pass++;
  endtask

  task automatic test_dp();
    bit ok;
    dat = 16'h5678; bright = 3'd7; dp_en = 1'b1; dp_ptr = 2'd2;
    run_to_frame(ok);
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      n_total++;
      if (seg[7] !== !(an === 4'hB))
        $display("FAIL dp_ptr2: got dp=%b an=%h expected dp=%b", seg[7], an, !(an === 4'hB));
      else n_pass++;
    end
    dp_en = 1'b0;
  endtask

  task automatic test_blink();
    bit ok;
    int blank_cnt, shown_cnt;
    dat = 16'h1234; bright = 3'd7; blink_mask = 4'b0001;
    run_to_frame(ok);
    tick();
    blank_cnt = 0; shown_cnt = 0;
    for (int i = 0; i < 160; i++) begin
      tick();
      if (an === 4'hE) begin
        if (seg[6:0] === 7'h7F) blank_cnt++;
        else if (seg[6:0] === 7'h19) shown_cnt++;
      end
      n_total++;
      if (an !== e_an || seg !== e_seg)
        $display("FAIL blink_model: got an=%h seg=%h expected an=%h seg=%h", an, seg, e_an, e_seg);
      else n_pass++;
    end
    n_total += 2;
    if (blank_cnt != 20) $display("FAIL blink_blank_cycles: got %0d expected 20", blank_cnt); else n_pass++;
    if (shown_cnt != 20) $display("FAIL blink_shown_cycles: got %0d expected 20", shown_cnt); else n_pass++;
    blink_mask = '0;
  endtask

`ifdef DISP_LZB_EN
  task automatic test_lzb();
    bit ok;
    logic [6:0] want [4] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
    dat = 16'h0040; bright = 3'd7;
    run_to_frame(ok);
    tick();
    for (int i = 0; i < 40; i++) begin
      tick();
      for (int d = 0; d < 4; d++)
        if (an === ~(4'b0001 << d)) begin
          n_total++;
          if (seg[6:0] !== want[d]) $display("FAIL lzb_digit%0d: got %h expected %h", d, seg[6:0], want[d]);
          else n_pass++;
        end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int d = 0; d < 4; d++) dat[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bright     = 3'($urandom);
      if ($urandom_range(0, 15) == 0) dp_en      = 1'($urandom);
      if ($urandom_range(0, 15) == 0) dp_ptr     = 2'($urandom);
      if ($urandom_range(0, 15) == 0) blink_mask = 4'($urandom);
      tick();
      n_total += 4;
      if (an !== e_an) $display("FAIL rand_an: k=%0d got %h expected %h", k, an, e_an); else n_pass++;
      if (seg !== e_seg) $display("FAIL rand_seg: k=%0d got %h expected %h", k, seg, e_seg); else n_pass++;
      if (ce_tick !== e_ce) $display("FAIL rand_ce: k=%0d got %b expected %b", k, ce_tick, e_ce); else n_pass++;
      if (frame !== e_fr) $display("FAIL rand_frame: k=%0d got %b expected %b", k, frame, e_fr); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = int'($urandom_range(5, 35));
    for (int i = 0; i < n; i++) tick();
    rst = 1'b1;
    tick();
    n_total++;
    if (an !== 4'hF || seg !== 8'hFF || ce_tick !== 1'b0 || frame !== 1'b0)
      $display("FAIL midreset_blank: got an=%h seg=%h ce=%b fr=%b expected f/ff/0/0", an, seg, ce_tick, frame);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (an !== 4'hE || seg !== 8'hC0)
      $display("FAIL midreset_restart: got an=%h seg=%h expected an=e seg=c0", an, seg);
    else n_pass++;
    for (int i = 0; i < 60; i++) begin
      tick();
      n_total++;
      if (an !== e_an || seg !== e_seg || ce_tick !== e_ce || frame !== e_fr)
        $display("FAIL midreset_model: got an=%h seg=%h ce=%b fr=%b expected %h %h %b %b",
                 an, seg, ce_tick, frame, e_an, e_seg, e_ce, e_fr);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1;
    k = 0;
    test_reset();
    test_scan();
    test_bright();
    test_tearing();
    test_dp();
    test_blink();
`ifdef DISP_LZB_EN
    test_lzb();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
